// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        input handshake (op, a, b, in_tag)
//   out_valid / out_ready      output handshake (result, flags, out_tag)
//   op                         000 ADD, 001 SUB, 010 AND, 011 OR,
//                              100 XOR, 101 NAND, 110 SHL, 111 SHR
//   flag_c / flag_z / flag_v   carry-borrow-shiftout / zero / signed overflow
//
// S1 holds the operands, S2 holds the computed result and drives the outputs.
// Each stage loads whenever the stage after it can take its contents, so a
// bubble is always overwritten and at most two beats are ever in flight.
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_v,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SH_W = $clog2(WIDTH);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_SHL  = 3'b110;
   localparam logic [2:0] OP_SHR  = 3'b111;

   logic             r_s1_valid;
   logic [2:0]       r_s1_op;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [TAG_W-1:0] r_s1_tag;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_s2_result;
   logic             r_s2_c;
   logic             r_s2_v;
   logic [TAG_W-1:0] r_s2_tag;

   logic             w_adv1;
   logic             w_adv2;

   logic [SH_W-1:0]  w_sh;
   logic [WIDTH:0]   w_add_ext;
   logic [WIDTH:0]   w_sub_ext;
   logic [WIDTH:0]   w_shl_ext;
   logic [WIDTH:0]   w_shr_ext;
   logic [WIDTH-1:0] w_res;
   logic             w_c;
   logic             w_v;

   assign w_adv2   = !r_s2_valid || out_ready;
   assign w_adv1   = !r_s1_valid || w_adv2;
   assign in_ready = w_adv1;

   assign w_sh      = r_s1_b[SH_W-1:0];
   assign w_add_ext = {1'b0, r_s1_a} + {1'b0, r_s1_b};
   // MSB of the extended difference is the borrow, i.e. a < b.
   assign w_sub_ext = {1'b0, r_s1_a} - {1'b0, r_s1_b};
   // One guard bit on the side the data leaves catches the last bit shifted
   // out; it stays 0 for a zero shift.
   assign w_shl_ext = {1'b0, r_s1_a} << w_sh;
   assign w_shr_ext = {r_s1_a, 1'b0} >> w_sh;

   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (r_s1_op)
         OP_ADD: begin
            w_res = w_add_ext[WIDTH-1:0];
            w_c   = w_add_ext[WIDTH];
            w_v   = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                    (w_add_ext[WIDTH-1] != r_s1_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_sub_ext[WIDTH-1:0];
            w_c   = w_sub_ext[WIDTH];
            w_v   = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) &&
                    (w_sub_ext[WIDTH-1] != r_s1_a[WIDTH-1]);
         end
         OP_AND:  w_res = r_s1_a & r_s1_b;
         OP_OR:   w_res = r_s1_a | r_s1_b;
         OP_XOR:  w_res = r_s1_a ^ r_s1_b;
         OP_NAND: w_res = ~(r_s1_a & r_s1_b);
         OP_SHL: begin
            w_res = w_shl_ext[WIDTH-1:0];
            w_c   = w_shl_ext[WIDTH];
         end
         OP_SHR: begin
            w_res = w_shr_ext[WIDTH:1];
            w_c   = w_shr_ext[0];
         end
         default: begin
            w_res = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_op     <= '0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s1_tag    <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_result <= '0;
         r_s2_c      <= 1'b0;
         r_s2_v      <= 1'b0;
         r_s2_tag    <= '0;
      end else begin
         if (w_adv1) begin
            r_s1_valid <= in_valid;
            r_s1_op    <= op;
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s1_tag   <= in_tag;
         end
         if (w_adv2) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_result <= w_res;
            r_s2_c      <= w_c;
            r_s2_v      <= w_v;
            r_s2_tag    <= r_s1_tag;
         end
      end
   end

   // Data registers may hold leftovers from a bubble; outputs read 0 unless valid.
   assign out_valid = r_s2_valid;
   assign result    = r_s2_valid ? r_s2_result : '0;
   assign flag_c    = r_s2_valid && r_s2_c;
   assign flag_v    = r_s2_valid && r_s2_v;
   assign flag_z    = r_s2_valid && (r_s2_result == '0);
   assign out_tag   = r_s2_valid ? r_s2_tag : '0;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       iv8, ir8, ov8, or8, c8, z8, v8;
   logic [2:0] op8;
   logic [7:0] a8, b8, res8;
   logic [3:0] tag8, otag8;

   // WIDTH=16 instance
   logic        iv16, ir16, ov16, or16, c16, z16, v16;
   logic [2:0]  op16;
   logic [15:0] a16, b16, res16;
   logic [3:0]  tag16, otag16;

   alu_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv8), .in_ready(ir8), .op(op8), .a(a8), .b(b8), .in_tag(tag8),
      .out_valid(ov8), .out_ready(or8), .result(res8),
      .flag_c(c8), .flag_z(z8), .flag_v(v8), .out_tag(otag8)
   );

   alu_pipe #(.WIDTH(16), .TAG_W(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv16), .in_ready(ir16), .op(op16), .a(a16), .b(b16), .in_tag(tag16),
      .out_valid(ov16), .out_ready(or16), .result(res16),
      .flag_c(c16), .flag_z(z16), .flag_v(v16), .out_tag(otag16)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, obs, exp);
      end
   endtask

   // Packed view {valid, tag, c, z, v, res} of the 8-bit outputs.
   function automatic logic [31:0] obs8();
      return {16'h0, ov8, otag8, c8, z8, v8, res8};
   endfunction

   function automatic logic [31:0] pk8(input logic vld, input logic [3:0] t,
                                       input logic c, input logic z, input logic v,
                                       input logic [7:0] r);
      return {16'h0, vld, t, c, z, v, r};
   endfunction

   // Reference model written on integers with a signed-range overflow test.
   // Returns {c, z, v, res[15:0]}.
   function automatic logic [18:0] model(input int w, input int op, input int a, input int b);
      int   mask, msb, res, sa, sb, s, sh;
      logic c, v;
      mask = (1 << w) - 1;
      msb  = 1 << (w - 1);
      sa   = (a >= msb) ? a - 2 * msb : a;
      sb   = (b >= msb) ? b - 2 * msb : b;
      sh   = b % w;
      res  = 0;
      c    = 1'b0;
      v    = 1'b0;
      case (op)
         0: begin
            res = (a + b) & mask;
            c   = ((a + b) > mask);
            s   = sa + sb;
            v   = (s > msb - 1) || (s < -msb);
         end
         1: begin
            res = (a - b) & mask;
            c   = (a < b);
            s   = sa - sb;
            v   = (s > msb - 1) || (s < -msb);
         end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: res = (~(a & b)) & mask;
         6: begin
            res = (a << sh) & mask;
            c   = (sh != 0) && (((a >> (w - sh)) & 1) == 1);
         end
         default: begin
            res = a >> sh;
            c   = (sh != 0) && (((a >> (sh - 1)) & 1) == 1);
         end
      endcase
      return {c, (res == 0), v, res[15:0]};
   endfunction

   task automatic set8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] t);
      op8 = op; a8 = a; b8 = b; tag8 = t; iv8 = 1'b1;
   endtask

   task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] t);
      set8(op, a, b, t);
      @(posedge clk); #1;
      iv8 = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   logic [31:0] q8[$];
   logic [31:0] q16[$];

   initial begin
      logic        hold8, hold16, acc8, acc16;
      logic [31:0] last8, last16, o8, o16;
      int          N;

      iv8 = 0; or8 = 1; op8 = 0; a8 = 0; b8 = 0; tag8 = 0;
      iv16 = 0; or16 = 1; op16 = 0; a16 = 0; b16 = 0; tag16 = 0;

      // Reset state
      #3;
      chk("reset_out", obs8(), pk8(0, 0, 0, 0, 0, 8'h00));
      chk("reset_in_ready", {31'h0, ir8}, 32'd1);
      #9 rst_n = 1'b1;
      step();

      // Back-to-back ADD/SUB with out_ready high
      issue8(3'b000, 8'hFF, 8'h01, 4'h1);
      @(negedge clk);
      chk("lat_not_yet", {31'h0, ov8}, 32'd0);
      issue8(3'b001, 8'h80, 8'h01, 4'h2);
      @(negedge clk);
      chk("add_ff_01", obs8(), pk8(1, 4'h1, 1, 1, 0, 8'h00));
      step(); @(negedge clk);
      chk("sub_80_01", obs8(), pk8(1, 4'h2, 0, 0, 1, 8'h7F));
      step(); @(negedge clk);
      chk("drained_zero", obs8(), pk8(0, 0, 0, 0, 0, 8'h00));

      // Shifts, back-to-back
      step();
      issue8(3'b110, 8'h81, 8'h01, 4'h3);
      issue8(3'b111, 8'h81, 8'h01, 4'h4);
      @(negedge clk);
      chk("shl_81_1", obs8(), pk8(1, 4'h3, 1, 0, 0, 8'h02));
      issue8(3'b110, 8'h81, 8'h00, 4'h5);
      @(negedge clk);
      chk("shr_81_1", obs8(), pk8(1, 4'h4, 1, 0, 0, 8'h40));
      step(); @(negedge clk);
      chk("shl_81_0", obs8(), pk8(1, 4'h5, 0, 0, 0, 8'h81));
      step();

      // Backpressure with logic ops: two accepted, third refused
      or8 = 1'b0;
      issue8(3'b010, 8'hF0, 8'h3C, 4'h6);
      issue8(3'b011, 8'hF0, 8'h3C, 4'h7);
      set8(3'b100, 8'hF0, 8'h3C, 4'h8);
      @(negedge clk);
      chk("full_in_ready", {31'h0, ir8}, 32'd0);
      chk("and_held", obs8(), pk8(1, 4'h6, 0, 0, 0, 8'h30));
      step(); @(negedge clk);
      chk("full_in_ready2", {31'h0, ir8}, 32'd0);
      chk("and_stable", obs8(), pk8(1, 4'h6, 0, 0, 0, 8'h30));
      step();
      or8 = 1'b1;
      @(negedge clk);
      chk("in_ready_follows_out_ready", {31'h0, ir8}, 32'd1);
      chk("and_still", obs8(), pk8(1, 4'h6, 0, 0, 0, 8'h30));
      step();
      iv8 = 1'b0;
      @(negedge clk);
      chk("or_f0_3c", obs8(), pk8(1, 4'h7, 0, 0, 0, 8'hFC));
      step(); @(negedge clk);
      chk("xor_f0_3c", obs8(), pk8(1, 4'h8, 0, 0, 0, 8'hCC));
      step(); @(negedge clk);
      chk("bp_drained", obs8(), pk8(0, 0, 0, 0, 0, 8'h00));
      step();
      issue8(3'b101, 8'hF0, 8'h3C, 4'h9);
      step(); @(negedge clk);
      chk("nand_f0_3c", obs8(), pk8(1, 4'h9, 0, 0, 0, 8'hCF));
      step();

      // Reset mid-stream with two beats in flight
      or8 = 1'b0;
      issue8(3'b000, 8'h12, 8'h34, 4'hA);
      issue8(3'b000, 8'h56, 8'h01, 4'hB);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_out", obs8(), pk8(0, 0, 0, 0, 0, 8'h00));
      chk("rst_mid_in_ready", {31'h0, ir8}, 32'd1);
      #2 rst_n = 1'b1;
      or8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rst_no_stale", {31'h0, ov8}, 32'd0);
      end
      step();

      // Random traffic on both widths against the reference model
      N = 600;
      hold8 = 0; hold16 = 0; acc8 = 0; acc16 = 0; last8 = 0; last16 = 0;
      for (int cyc = 0; cyc < N + 20; cyc++) begin
         @(negedge clk);
         o8  = {ov8, 8'h0, otag8, c8, z8, v8, 8'h00, res8};
         o16 = {ov16, 8'h0, otag16, c16, z16, v16, res16};
         if (hold8)  chk("stall_stable8", o8, last8);
         if (hold16) chk("stall_stable16", o16, last16);
         if (ov8 && or8) begin
            if (q8.size() == 0) chk("spurious8", 32'd1, 32'd0);
            else                chk("rnd8", o8, q8.pop_front());
         end
         if (ov16 && or16) begin
            if (q16.size() == 0) chk("spurious16", 32'd1, 32'd0);
            else                 chk("rnd16", o16, q16.pop_front());
         end
         hold8  = ov8 && !or8;
         hold16 = ov16 && !or16;
         last8  = o8;
         last16 = o16;
         acc8   = iv8 && ir8;
         acc16  = iv16 && ir16;
         if (acc8)  q8.push_back({1'b1, 8'h0, tag8, model(8, int'(op8), int'(a8), int'(b8))});
         if (acc16) q16.push_back({1'b1, 8'h0, tag16, model(16, int'(op16), int'(a16), int'(b16))});
         step();
         if (!iv8 || acc8) begin
            iv8  = (cyc < N) && ($urandom_range(0, 3) != 0);
            op8  = 3'($urandom_range(0, 7));
            a8   = 8'($urandom_range(0, 255));
            b8   = 8'($urandom_range(0, 255));
            tag8 = 4'($urandom_range(0, 15));
         end
         if (!iv16 || acc16) begin
            iv16  = (cyc < N) && ($urandom_range(0, 3) != 0);
            op16  = 3'($urandom_range(0, 7));
            a16   = 16'($urandom_range(0, 65535));
            b16   = 16'($urandom_range(0, 65535));
            tag16 = 4'($urandom_range(0, 15));
         end
         or8  = (cyc >= N) || ($urandom_range(0, 2) != 0);
         or16 = (cyc >= N) || ($urandom_range(0, 2) != 0);
      end
      chk("q8_drained", q8.size(), 32'd0);
      chk("q16_drained", q16.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
